// File: rtl/multibyte_add_sequencer.sv
// Byte-serial front end for an external 8-bit carry-in adder: NBYTES-wide add (or subtract with SUBTRACT_EN).
// Latency: handshake at edge k -> out_valid after edge k+NBYTES; one op per NBYTES+2 cycles at best.
// Backpressure: in_ready only in IDLE; result/co held in DONE until out_ready. Option macro: SUBTRACT_EN.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NBYTES*8-1:0]   opa,
  input  logic [NBYTES*8-1:0]   opb,
  input  logic                  cin,
`ifdef SUBTRACT_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NBYTES*8-1:0]   result,
  output logic                  co,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_ci,
  input  logic [7:0]            add_sum
);

  localparam int IDXW = $clog2(NBYTES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_nx;
  logic [IDXW-1:0]   idx_q;
  logic [NBYTES*8-1:0] opa_q, opb_q;
  logic              carry_q;
  logic [7:0]        byte_a, byte_b;
  logic              last_byte;
  logic              carry_nx;
  logic              accept;
`ifdef SUBTRACT_EN
  logic              sub_q;
`endif

  assign last_byte = (idx_q == IDXW'(NBYTES - 1));
  assign accept    = in_valid && (state_q == IDLE);

  // The adder has no carry-out, so recover it from the MSBs of its inputs and sum
  assign carry_nx = (add_a[7] & add_b[7]) | ((add_a[7] | add_b[7]) & ~add_sum[7]);

  // Pick the operand byte pair addressed by the current index
  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDXW'(i)) begin
        byte_a = opa_q[8*i +: 8];
        byte_b = opb_q[8*i +: 8];
      end
    end
  end

  // Drive the adder only while running; quiet zeros otherwise
  always_comb begin
    add_a  = 8'd0;
    add_b  = 8'd0;
    add_ci = 1'b0;
    if (state_q == RUN) begin
      add_a  = byte_a;
`ifdef SUBTRACT_EN
      add_b  = sub_q ? ~byte_b : byte_b;
`else
      add_b  = byte_b;
`endif
      add_ci = carry_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx  = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last_byte) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, per-byte result collection and carry chaining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      co      <= 1'b0;
`ifdef SUBTRACT_EN
      sub_q   <= 1'b0;
`endif
    end else if (accept) begin
      opa_q <= opa;
      opb_q <= opb;
      idx_q <= '0;
`ifdef SUBTRACT_EN
      sub_q   <= sub;
      // Subtraction is A + ~B + 1, so the incoming carry is forced
      carry_q <= sub ? 1'b1 : cin;
`else
      carry_q <= cin;
`endif
    end else if (state_q == RUN) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (idx_q == IDXW'(i)) result[8*i +: 8] <= add_sum;
      end
      carry_q <= carry_nx;
      if (last_byte) begin
        co    <= carry_nx;
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
module tb_multibyte_add_sequencer;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, out_valid, out_ready, co, add_ci;
  logic [31:0] opa, opb, result;
  logic [7:0]  add_a, add_b, add_sum;
`ifdef SUBTRACT_EN
  logic        sub;
  logic        sub1;
`endif

  logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, co1, add_ci1;
  logic [7:0]  opa1, opb1, result1, add_a1, add_b1, add_sum1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural 8-bit adder with carry-in, no carry-out
  assign add_sum  = add_a + add_b + {7'd0, add_ci};
  assign add_sum1 = add_a1 + add_b1 + {7'd0, add_ci1};

  multibyte_add_sequencer #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opa(opa), .opb(opb), .cin(cin),
`ifdef SUBTRACT_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .co(co),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_sum(add_sum)
  );

  multibyte_add_sequencer #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .opa(opa1), .opb(opb1), .cin(cin1),
`ifdef SUBTRACT_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .result(result1), .co(co1),
    .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1), .add_sum(add_sum1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full-width reference: {carry-out, sum} of A + B' + c'
  function automatic logic [32:0] model_sum(input logic [31:0] a, input logic [31:0] b,
                                            input logic c, input logic s);
    logic [31:0] be;
    logic        ce;
    be = s ? ~b : b;
    ce = s ? 1'b1 : c;
    return {1'b0, a} + {1'b0, be} + 33'(ce);
  endfunction

  // Carry entering byte j: carry out of the sum of the low j bytes
  function automatic logic model_cin(input logic [31:0] a, input logic [31:0] b,
                                     input logic c, input logic s, input int j);
    logic [31:0] be, m;
    logic [32:0] t;
    logic        ce;
    be = s ? ~b : b;
    ce = s ? 1'b1 : c;
    m  = (32'h1 << (8*j)) - 32'h1;
    t  = {1'b0, a & m} + {1'b0, be & m} + 33'(ce);
    return t[8*j];
  endfunction

  // One operation on the 4-byte instance; entered and left just after a clock edge with the DUT idle
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                       input bit hold, input int stall, input string tag);
    logic [32:0] exp;
    logic [31:0] be;
    int          cnt;
    exp = model_sum(a, b, c, s);
    be  = s ? ~b : b;
    check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    opa = a; opb = b; cin = c; in_valid = 1'b1; out_ready = hold;
`ifdef SUBTRACT_EN
    sub = s;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0; opa = $urandom; opb = $urandom; cin = 1'($urandom);
`ifdef SUBTRACT_EN
    sub = 1'($urandom);
`endif
    cnt = 0;
    while (!out_valid && cnt < 3*NB) begin
      if (cnt < NB) begin
        check({tag, " add_a"},  64'(add_a),  64'(a[8*cnt +: 8]));
        check({tag, " add_b"},  64'(add_b),  64'(be[8*cnt +: 8]));
        check({tag, " add_ci"}, 64'(add_ci), 64'(model_cin(a, b, c, s, cnt)));
        check({tag, " in_ready run"}, 64'(in_ready), 64'd0);
      end
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, " latency"}, 64'(cnt), 64'(NB));
    check({tag, " result"}, 64'(result), 64'(exp[31:0]));
    check({tag, " co"}, 64'(co), 64'(exp[32]));
    check({tag, " add idle"}, 64'({add_a, add_b, add_ci}), 64'd0);
    if (hold) begin
      @(posedge clk); #1;
      check({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
      check({tag, " back idle"}, 64'(in_ready), 64'd1);
      out_ready = 1'b0;
    end else begin
      for (int k = 0; k < stall; k++) begin
        check({tag, " stall out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " stall in_ready"}, 64'(in_ready), 64'd0);
        check({tag, " stall result"}, 64'({co, result}), 64'(exp));
        if (k == 1) begin
          in_valid = 1'b1; opa = $urandom; opb = $urandom;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " released"}, 64'(out_valid), 64'd0);
      check({tag, " back idle"}, 64'(in_ready), 64'd1);
      check({tag, " result kept"}, 64'({co, result}), 64'(exp));
    end
  endtask

  // One operation on the single-byte instance
  task automatic do_op1(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    logic [8:0] exp;
    exp = {1'b0, a} + {1'b0, b} + 9'(c);
    check({tag, " in_ready"}, 64'(in_ready1), 64'd1);
    opa1 = a; opb1 = b; cin1 = c; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; opa1 = 8'($urandom); opb1 = 8'($urandom);
    check({tag, " run add"}, 64'({add_a1, add_b1, add_ci1}), 64'({a, b, c}));
    check({tag, " run out_valid"}, 64'(out_valid1), 64'd0);
    @(posedge clk); #1;
    check({tag, " out_valid"}, 64'(out_valid1), 64'd1);
    check({tag, " sum"}, 64'({co1, result1}), 64'(exp));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check({tag, " released"}, 64'(out_valid1), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opa = '0; opb = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; opa1 = '0; opb1 = '0; cin1 = 1'b0;
`ifdef SUBTRACT_EN
    sub = 1'b0; sub1 = 1'b0;
`endif
    #12;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'({co, result}), 64'd0);
    check("reset adder", 64'({add_a, add_b, add_ci}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 0, "ripple");
    do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 0, "cin");
    do_op(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b0, 1'b0, 5, "stall");

    // Abort a run after two bytes have been summed
    opa = 32'h8080_8080; opb = 32'h8080_8080; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst adder", 64'({add_a, add_b, add_ci}), 64'd0);
    check("midrst result", 64'({co, result}), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h0102_0304, 32'h0506_0708, 1'b0, 1'b0, 1'b1, 0, "post reset");

`ifdef SUBTRACT_EN
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1, 0, "sub borrow");
    do_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b1, 0, "sub noborrow");
`endif

    for (int n = 0; n < 20; n++) begin
      ra = $urandom; rb = $urandom;
      if (n % 5 == 0) rb = ~ra;
`ifdef SUBTRACT_EN
      do_op(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3), "random");
`else
      do_op(ra, rb, 1'($urandom), 1'b0, 1'($urandom), $urandom_range(0, 3), "random");
`endif
    end

    do_op1(8'h80, 8'h80, 1'b0, "nb1 msb");
    do_op1(8'hFF, 8'h00, 1'b1, "nb1 cin");
    do_op1(8'($urandom), 8'($urandom), 1'($urandom), "nb1 random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
